// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide with a stall request to the hazard unit.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]       r_func3;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_acc;
  logic [WIDTH-1:0] r_opnd;
  logic             r_neg_res;
  logic             r_neg_rem;

  logic             w_accept;
  logic             w_fix;
  logic             w_is_div;
  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_div_zero;
  logic             w_div_ovf;
  logic             w_fast;
  logic [WIDTH-1:0] w_fast_res;

  // Operand decode at accept: signedness, magnitudes, divide special cases
  assign w_is_div   = func3[2];
  assign w_a_signed = (func3 == 3'd1) | (func3 == 3'd2) | (func3 == 3'd4) | (func3 == 3'd6);
  assign w_b_signed = (func3 == 3'd1) | (func3 == 3'd4) | (func3 == 3'd6);
  assign w_a_neg    = w_a_signed & op_a[WIDTH-1];
  assign w_b_neg    = w_b_signed & op_b[WIDTH-1];
  assign w_mag_a    = w_a_neg ? -op_a : op_a;
  assign w_mag_b    = w_b_neg ? -op_b : op_b;
  assign w_div_zero = w_is_div & (op_b == '0);
  assign w_div_ovf  = w_is_div & ~func3[0] & (op_a == INT_MIN) & (&op_b);
  assign w_fast     = w_div_zero | w_div_ovf;

  always_comb begin
    w_fast_res = '0;
    if (w_div_zero) begin
      w_fast_res = func3[1] ? op_a : '1;
    end else if (w_div_ovf) begin
      w_fast_res = func3[1] ? '0 : INT_MIN;
    end
  end

  // Iteration datapaths; r_acc holds {hi, lo} product or {remainder, quotient}
  logic [WIDTH:0]   w_mul_sum;
  logic [PW-1:0]    w_mul_step;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic [PW-1:0]    w_div_step;

  assign w_mul_sum  = {1'b0, r_acc[PW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_shift    = r_acc[PW-1:WIDTH-1];
  assign w_diff     = {1'b0, w_shift} - {2'b0, r_opnd};
  assign w_div_step = w_diff[WIDTH+1]
                    ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                    : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  // Sign correction and result selection applied in FIX
  logic [PW-1:0]    w_prod_s;
  logic [WIDTH-1:0] w_quo_s;
  logic [WIDTH-1:0] w_rem_s;
  logic [WIDTH-1:0] w_fix_res;

  assign w_prod_s = r_neg_res ? -r_acc : r_acc;
  assign w_quo_s  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_s  = r_neg_rem ? -r_acc[PW-1:WIDTH] : r_acc[PW-1:WIDTH];

  always_comb begin
    w_fix_res = w_rem_s;
    case (r_func3)
      3'd0:                  w_fix_res = w_prod_s[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:      w_fix_res = w_prod_s[PW-1:WIDTH];
      3'd4, 3'd5:            w_fix_res = w_quo_s;
      default:               w_fix_res = w_rem_s;
    endcase
  end

  assign stall_req = start & ~flush & (r_state != ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; flush overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_fast ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_accept    = 1'b0;
      w_fix       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_func3   <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (w_state_nxt == ST_CALC) | (w_state_nxt == ST_FIX);
      done <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_func3   <= func3;
        rd_out    <= rd_in;
        r_cnt     <= '0;
        r_neg_res <= w_a_neg ^ w_b_neg;
        r_neg_rem <= w_a_neg;
        r_acc     <= w_is_div ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
        r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
        if (w_fast) begin
          result <= w_fast_res;
        end
      end else if ((r_state == ST_CALC) && !flush) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= r_func3[2] ? w_div_step : w_mul_step;
      end else if (w_fix) begin
        result <= w_fix_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  func3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .func3(func3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall_req(stall_req),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one op from IDLE and waits (bounded) for done; operands are scrambled after accept
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output bit stall_ok, output bit single);
    func3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    #1;
    stall_ok = (stall_req === 1'b1);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) break;
      if (stall_req !== 1'b1) stall_ok = 1'b0;
      if (lat == 1) begin op_a = ~a; op_b = 32'h3; rd_in = ~rd; end
    end
    res = result;
    rdo = rd_out;
    if (stall_req !== 1'b0) stall_ok = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    single = (done === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, done, stall_req} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {busy, done, stall_req}); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (rd_out !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", rd_out); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] res; logic [4:0] rdo; int lat; bit st; bit sg;
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, res, rdo, lat, st, sg);
    checks++; if (res !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL mul_latency got=%0d exp=34", lat); end
    checks++; if (rdo !== 5'd5) begin failures++; $display("FAIL mul_rd got=%0d exp=5", rdo); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL mul_stall got=%0d exp=1", st); end
    checks++; if (sg !== 1'b1) begin failures++; $display("FAIL mul_single_done got=%0d exp=1", sg); end
  endtask

  task automatic test_mulh();
    logic [2:0]  fv [3] = '{3'd1, 3'd2, 3'd3};
    logic [31:0] av [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bv [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev [3] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] res; logic [4:0] rdo; int lat; bit st; bit sg;
    for (int i = 0; i < 3; i++) begin
      run_op(fv[i], av[i], bv[i], 5'(i + 1), res, rdo, lat, st, sg);
      checks++; if (res !== ev[i]) begin failures++; $display("FAIL mulh_f%0d got=%h exp=%h", fv[i], res, ev[i]); end
      checks++; if (lat !== 34) begin failures++; $display("FAIL mulh_f%0d_latency got=%0d exp=34", fv[i], lat); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  fv [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] av [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] bv [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ev [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    logic [31:0] res; logic [4:0] rdo; int lat; bit st; bit sg;
    for (int i = 0; i < 4; i++) begin
      run_op(fv[i], av[i], bv[i], 5'(i + 10), res, rdo, lat, st, sg);
      checks++; if (res !== ev[i]) begin failures++; $display("FAIL div_f%0d got=%h exp=%h", fv[i], res, ev[i]); end
      checks++; if (lat !== 34) begin failures++; $display("FAIL div_f%0d_latency got=%0d exp=34", fv[i], lat); end
      checks++; if (rdo !== 5'(i + 10)) begin failures++; $display("FAIL div_f%0d_rd got=%0d exp=%0d", fv[i], rdo, i + 10); end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  fv [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] av [4] = '{32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
    logic [31:0] bv [4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev [4] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
    logic [31:0] res; logic [4:0] rdo; int lat; bit st; bit sg;
    for (int i = 0; i < 4; i++) begin
      run_op(fv[i], av[i], bv[i], 5'(i + 20), res, rdo, lat, st, sg);
      checks++; if (res !== ev[i]) begin failures++; $display("FAIL fast_f%0d got=%h exp=%h", fv[i], res, ev[i]); end
      checks++; if (lat !== 1) begin failures++; $display("FAIL fast_f%0d_latency got=%0d exp=1", fv[i], lat); end
      checks++; if (sg !== 1'b1) begin failures++; $display("FAIL fast_f%0d_single got=%0d exp=1", fv[i], sg); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [4:0] rdo; int lat; bit st; bit sg;
    run_op(3'd5, 32'd100, 32'd7, 5'd8, res, rdo, lat, st, sg);
    func3 = 3'd4; op_a = 32'hFFFFFFF9; op_b = 32'd2; rd_in = 5'd9; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall_req); end
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL flush_ctrl got=%b exp=00", {busy, done}); end
    checks++; if (result !== 32'd14) begin failures++; $display("FAIL flush_result_hold got=%h exp=e", result); end
    checks++; if (rd_out !== 5'd9) begin failures++; $display("FAIL flush_rd_hold got=%0d exp=9", rd_out); end
    run_op(3'd7, 32'd100, 32'd7, 5'd11, res, rdo, lat, st, sg);
    checks++; if (res !== 32'd2) begin failures++; $display("FAIL flush_next_result got=%h exp=2", res); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL flush_next_latency got=%0d exp=34", lat); end
  endtask

  task automatic test_reset_mid();
    func3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFFFFFD; rd_in = 5'd5; start = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1; start = 1'b0;
    #1;
    checks++; if ({busy, done, stall_req} !== 3'b000) begin failures++; $display("FAIL rstmid_ctrl got=%b exp=000", {busy, done, stall_req}); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", result); end
    checks++; if (rd_out !== 5'd0) begin failures++; $display("FAIL rstmid_rd got=%0d exp=0", rd_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int edge2 = 0;
    logic [31:0] r1 = '0;
    logic [31:0] r2 = '0;
    logic [4:0]  d1 = '0;
    logic [4:0]  d2 = '0;
    func3 = 3'd0; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd3; start = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          r1 = result; d1 = rd_out;
          func3 = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd4;
        end else if (ndone == 2) begin
          r2 = result; d2 = rd_out; edge2 = e;
          start = 1'b0;
        end
      end
    end
    checks++; if (ndone !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", ndone); end
    checks++; if (r1 !== 32'd42 || d1 !== 5'd3) begin failures++; $display("FAIL b2b_first got=%h/%0d exp=2a/3", r1, d1); end
    checks++; if (r2 !== 32'd14 || d2 !== 5'd4) begin failures++; $display("FAIL b2b_second got=%h/%0d exp=e/4", r2, d2); end
    checks++; if (edge2 !== 69) begin failures++; $display("FAIL b2b_second_edge got=%0d exp=69", edge2); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast_path();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
